// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the packet-aware FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Round-robin pointer advance: the source after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the offset back to a source index.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_SRC);

  logic [NUM_SRC-1:0] rot;
  logic [IDX_W:0]     j;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate the request vector so the source at ptr lands on bit 0.
  always_comb begin
    rot = '0;
    j   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = (IDX_W+1)'(i) + {1'b0, ptr};
      if (j >= N_EXT) j = j - N_EXT;
      rot[i] = req[j[IDX_W-1:0]];
    end
  end

  // Fixed priority on the rotated vector: lowest set bit wins.
  always_comb begin
    off = '0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign any     = |req;
  assign sum     = {1'b0, off} + {1'b0, ptr};
  assign gnt_idx = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : sum[IDX_W-1:0];
  assign gnt     = any ? (NUM_SRC'(1) << gnt_idx) : '0;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among
// NUM_SRC streaming sources. A source winning on a start-of-packet beat
// keeps the port until its end-of-packet beat is written.
//
//   state  | meaning
//   IDLE   | no owner; arbitrate among sop requests, accept no beats
//   LOCKED | owner in grant; its beats pass to the FIFO until eop accepted
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 32,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]       src_valid_i,
  input  logic [NUM_SRC-1:0]       src_sop_i,
  input  logic [NUM_SRC-1:0]       src_eop_i,
  output logic [NUM_SRC-1:0]       src_ready_o,
  output logic [WIDTH-1:0]         fifo_data_o,
  output logic                     fifo_wr_o,
  input  logic                     fifo_full_i,
  output logic [NUM_SRC-1:0]       grant_o,
  output logic                     busy_o,
  output logic                     err_o
);

  arb_state_t         state, state_next;
  logic [NUM_SRC-1:0] grant, grant_next;
  logic [IDX_W-1:0]   gidx, gidx_next;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_next;
  logic               first_beat, first_next;
  logic               err, err_next;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               locked;
  logic               accept;

  assign req = src_valid_i & src_sop_i;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign locked = (state == LOCKED);
  // Full stalls the owner without dropping the lock; the source holds its beat.
  assign accept = locked & src_valid_i[gidx] & ~fifo_full_i;

  // grant is all-zero in IDLE, so masking it with !full gives the ready vector.
  assign src_ready_o = grant & {NUM_SRC{~fifo_full_i}};
  assign fifo_wr_o   = accept;
  assign fifo_data_o = locked ? src_data_i[int'(gidx)*WIDTH +: WIDTH] : '0;
  assign grant_o     = grant;
  assign busy_o      = locked;
  assign err_o       = err;

  // Next-state logic: arbitration in IDLE, packet tracking and error detection in LOCKED.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    gidx_next   = gidx;
    rr_ptr_next = rr_ptr;
    first_next  = first_beat;
    err_next    = 1'b0;
    case (state)
      IDLE: begin
        // A beat offered without sop while nobody owns the port is a protocol slip.
        err_next = |(src_valid_i & ~src_sop_i);
        if (pick_any) begin
          state_next = LOCKED;
          grant_next = pick_gnt;
          gidx_next  = pick_idx;
          first_next = 1'b1;
        end
      end
      LOCKED: begin
        if (accept) begin
          first_next = 1'b0;
          // A repeated sop is still written; it only raises the flag.
          err_next   = src_sop_i[gidx] & ~first_beat;
          if (src_eop_i[gidx]) begin
            state_next  = IDLE;
            grant_next  = '0;
            gidx_next   = '0;
            rr_ptr_next = IDX_W'(rr_next(32'(gidx), NUM_SRC));
          end
        end
      end
    endcase
  end

  // State register; reset drops any lock immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      gidx       <= gidx_next;
      rr_ptr     <= rr_ptr_next;
      first_beat <= first_next;
      err        <= err_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus a randomized
// phase, all outputs compared each cycle against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] src_data;
  logic [N-1:0] src_valid, src_sop, src_eop, src_ready, grant;
  logic [W-1:0] fifo_data;
  logic         fifo_wr, fifo_full, busy, err;

  fifo_wr_arbiter #(.NUM_SRC(N), .WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_data_i  (src_data),
    .src_valid_i (src_valid),
    .src_sop_i   (src_sop),
    .src_eop_i   (src_eop),
    .src_ready_o (src_ready),
    .fifo_data_o (fifo_data),
    .fifo_wr_o   (fifo_wr),
    .fifo_full_i (fifo_full),
    .grant_o     (grant),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = nobody), round-robin pointer,
  // first-beat flag, pending error pulse and per-source acceptance.
  int       m_owner = -1;
  int       m_ptr   = 0;
  bit       m_first = 1'b0;
  bit       m_err   = 1'b0;
  bit [N-1:0] m_acc = '0;

  always @(posedge clk or posedge rst) begin : ref_model
    int own, ptr, k;
    bit fst, e;
    bit [N-1:0] acc;
    if (rst) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_first <= 1'b0;
      m_err   <= 1'b0;
      m_acc   <= '0;
    end else begin
      own = m_owner; ptr = m_ptr; fst = m_first; e = 1'b0; acc = '0;
      if (own < 0) begin
        e = |(src_valid & ~src_sop);
        for (int s = 0; s < N; s++) begin
          k = (ptr + s) % N;
          if (own < 0 && src_valid[k] && src_sop[k]) begin
            own = k;
            fst = 1'b1;
          end
        end
      end else if (src_valid[own] && !fifo_full) begin
        acc[own] = 1'b1;
        e = src_sop[own] && !fst;
        fst = 1'b0;
        if (src_eop[own]) begin
          ptr = (own + 1) % N;
          own = -1;
        end
      end
      m_owner <= own;
      m_ptr   <= ptr;
      m_first <= fst;
      m_err   <= e;
      m_acc   <= acc;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : scoreboard
    logic [N-1:0] eg, er;
    logic ew;
    logic [W-1:0] ed;
    if (!rst) begin
      eg = '0; er = '0; ew = 1'b0; ed = '0;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        if (!fifo_full) er[m_owner] = 1'b1;
        ew = src_valid[m_owner] && !fifo_full;
        ed = src_data[m_owner*W +: W];
      end
      chk("sb_grant", 64'(grant), 64'(eg));
      chk("sb_busy",  64'(busy),  64'(m_owner >= 0));
      chk("sb_ready", 64'(src_ready), 64'(er));
      chk("sb_wr",    64'(fifo_wr), 64'(ew));
      chk("sb_data",  64'(fifo_data), 64'(ed));
      chk("sb_err",   64'(err), 64'(m_err));
    end
  end

  int rem[N];
  bit pres[N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int k, input bit v, input bit s, input bit e, input logic [W-1:0] d);
    src_valid[k] = v;
    src_sop[k]   = s;
    src_eop[k]   = e;
    src_data[k*W +: W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = '0; src_sop = '0; src_eop = '0; src_data = '0; fifo_full = 1'b0;
    for (int k = 0; k < N; k++) begin
      rem[k] = 0;
      pres[k] = 1'b0;
    end
    #3;
    tick();
    rst = 1'b0;
  endtask

  task automatic present(input int k, input bit first);
    pres[k] = 1'b1;
    src_valid[k] = 1'b1;
    src_sop[k]   = first ? 1'b1 : ($urandom_range(11) == 0);
    src_eop[k]   = (rem[k] == 1);
    src_data[k*W +: W] = $urandom;
  endtask

  int order[$];
  int exp3[5] = '{0, 1, 2, 3, 0};
  int w8;

  initial begin
    rst = 1'b1;
    src_valid = '0; src_sop = '0; src_eop = '0; src_data = '0; fifo_full = 1'b0;
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'd0);
    chk("rst_wr",    64'(fifo_wr), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_data",  64'(fifo_data), 64'd0);

    // Single 3-beat packet from source 0, then pointer check.
    do_reset();
    beat(0, 1, 1, 0, 32'hA0);
    @(negedge clk); chk("t1_c0_ready", 64'(src_ready), 64'd0); chk("t1_c0_busy", 64'(busy), 64'd0);
    tick(); @(negedge clk);
    chk("t1_c1_grant", 64'(grant), 64'd1); chk("t1_c1_wr", 64'(fifo_wr), 64'd1); chk("t1_c1_data", 64'(fifo_data), 64'hA0);
    tick(); beat(0, 1, 0, 0, 32'hA1); @(negedge clk);
    chk("t1_c2_data", 64'(fifo_data), 64'hA1); chk("t1_c2_wr", 64'(fifo_wr), 64'd1);
    tick(); beat(0, 1, 0, 1, 32'hA2); @(negedge clk);
    chk("t1_c3_data", 64'(fifo_data), 64'hA2);
    tick(); beat(0, 0, 0, 0, 32'h0);
    beat(0, 1, 1, 1, 32'hB0); beat(1, 1, 1, 1, 32'hB1);
    @(negedge clk); chk("t1_c4_busy", 64'(busy), 64'd0);
    tick(); @(negedge clk); chk("t1_ptr1_grant", 64'(grant), 64'd2); chk("t1_ptr1_data", 64'(fifo_data), 64'hB1);
    tick(); beat(1, 0, 0, 0, 32'h0); @(negedge clk); chk("t1_bubble", 64'(grant), 64'd0);
    tick(); @(negedge clk); chk("t1_src0_grant", 64'(grant), 64'd1); chk("t1_src0_data", 64'(fifo_data), 64'hB0);
    tick(); beat(0, 0, 0, 0, 32'h0);

    // Simultaneous requests from sources 0 and 2.
    do_reset();
    beat(0, 1, 1, 0, 32'hC0); beat(2, 1, 1, 0, 32'hE0);
    tick(); @(negedge clk); chk("t2_c1_grant", 64'(grant), 64'd1); chk("t2_c1_ready", 64'(src_ready), 64'd1);
    tick(); beat(0, 1, 0, 1, 32'hC1); @(negedge clk); chk("t2_c2_data", 64'(fifo_data), 64'hC1);
    tick(); beat(0, 0, 0, 0, 32'h0); @(negedge clk); chk("t2_c3_bubble_wr", 64'(fifo_wr), 64'd0);
    tick(); @(negedge clk); chk("t2_c4_grant", 64'(grant), 64'd4); chk("t2_c4_data", 64'(fifo_data), 64'hE0);
    tick(); beat(2, 1, 0, 1, 32'hE1); @(negedge clk); chk("t2_c5_data", 64'(fifo_data), 64'hE1);
    tick(); beat(2, 0, 0, 0, 32'h0); @(negedge clk); chk("t2_c6_busy", 64'(busy), 64'd0);

    // All sources streaming single-beat packets.
    do_reset();
    for (int k = 0; k < N; k++) beat(k, 1, 1, 1, 32'hD0 + 32'(k));
    w8 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_wr) begin
        order.push_back(int'(fifo_data) - 32'hD0);
        if (c < 8) w8++;
      end
      tick();
    end
    chk("t3_writes_in_8", 64'(w8), 64'd4);
    chk("t3_writes_in_10", 64'(order.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk("t3_order", 64'(order[i]), 64'(exp3[i]));
    end
    src_valid = '0; src_sop = '0; src_eop = '0;

    // FIFO full during the second beat.
    do_reset();
    beat(1, 1, 1, 0, 32'h10);
    tick(); @(negedge clk); chk("t4_c1_data", 64'(fifo_data), 64'h10);
    tick(); beat(1, 1, 0, 0, 32'h11); fifo_full = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("t4_full_wr", 64'(fifo_wr), 64'd0);
      chk("t4_full_ready", 64'(src_ready), 64'd0);
      chk("t4_full_busy", 64'(busy), 64'd1);
      tick();
    end
    fifo_full = 1'b0;
    @(negedge clk); chk("t4_c5_wr", 64'(fifo_wr), 64'd1); chk("t4_c5_data", 64'(fifo_data), 64'h11);
    chk("t4_c5_grant", 64'(grant), 64'd2);
    tick(); beat(1, 1, 0, 1, 32'h12); @(negedge clk); chk("t4_c6_data", 64'(fifo_data), 64'h12);
    tick(); beat(1, 0, 0, 0, 32'h0); @(negedge clk); chk("t4_c7_busy", 64'(busy), 64'd0);

    // Protocol errors.
    do_reset();
    beat(1, 1, 0, 0, 32'h55);
    @(negedge clk); chk("t5_c0_ready", 64'(src_ready), 64'd0); chk("t5_c0_err", 64'(err), 64'd0);
    tick(); beat(1, 0, 0, 0, 32'h0); @(negedge clk);
    chk("t5_c1_err", 64'(err), 64'd1); chk("t5_c1_busy", 64'(busy), 64'd0);
    tick(); beat(1, 1, 1, 0, 32'h60); @(negedge clk); chk("t5_c2_err", 64'(err), 64'd0);
    tick(); @(negedge clk); chk("t5_c3_data", 64'(fifo_data), 64'h60);
    tick(); beat(1, 1, 1, 0, 32'h61); @(negedge clk);
    chk("t5_c4_wr", 64'(fifo_wr), 64'd1); chk("t5_c4_err", 64'(err), 64'd0);
    tick(); beat(1, 1, 0, 1, 32'h62); @(negedge clk);
    chk("t5_c5_err", 64'(err), 64'd1); chk("t5_c5_busy", 64'(busy), 64'd1);
    tick(); beat(1, 0, 0, 0, 32'h0); @(negedge clk);
    chk("t5_c6_err", 64'(err), 64'd0); chk("t5_c6_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-packet, pointer returns to 0.
    do_reset();
    beat(1, 1, 1, 1, 32'h70);
    tick(); @(negedge clk); chk("t6_c1_wr", 64'(fifo_wr), 64'd1);
    tick(); beat(1, 0, 0, 0, 32'h0); beat(2, 1, 1, 0, 32'h80);
    tick(); @(negedge clk); chk("t6_c3_grant", 64'(grant), 64'd4);
    tick(); beat(2, 1, 0, 0, 32'h81);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_grant", 64'(grant), 64'd0);
    chk("t6_arst_busy",  64'(busy), 64'd0);
    chk("t6_arst_ready", 64'(src_ready), 64'd0);
    chk("t6_arst_wr",    64'(fifo_wr), 64'd0);
    beat(2, 0, 0, 0, 32'h0);
    tick();
    rst = 1'b0;
    beat(1, 1, 1, 1, 32'h91); beat(3, 1, 1, 1, 32'h93);
    tick(); @(negedge clk); chk("t6_after_grant", 64'(grant), 64'd2); chk("t6_after_data", 64'(fifo_data), 64'h91);
    tick(); beat(1, 0, 0, 0, 32'h0);
    tick(); @(negedge clk); chk("t6_src3_grant", 64'(grant), 64'd8); chk("t6_src3_data", 64'(fifo_data), 64'h93);
    tick(); beat(3, 0, 0, 0, 32'h0);

    // Randomized traffic with stalls, stray beats and repeated sops.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (pres[k] && m_acc[k]) begin
          pres[k] = 1'b0;
          rem[k]--;
        end
        if (!pres[k]) begin
          src_valid[k] = 1'b0; src_sop[k] = 1'b0; src_eop[k] = 1'b0;
          if (rem[k] > 0) begin
            if ($urandom_range(3) != 0) present(k, 1'b0);
          end else if ($urandom_range(2) == 0) begin
            rem[k] = int'($urandom_range(4, 1));
            present(k, 1'b1);
          end else if ($urandom_range(19) == 0) begin
            src_valid[k] = 1'b1;
            src_eop[k]   = 1'($urandom_range(1));
            src_data[k*W +: W] = $urandom;
          end
        end
      end
      fifo_full = ($urandom_range(3) == 0);
    end
    src_valid = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
